// File: rtl/param_data_memory.sv
// Parametrised single-clock data memory: one write port, one pipelined read port,
// with a hardware clear engine that runs after reset and on request.
module param_data_memory #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    DEPTH        = 256,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable_write,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  enable_read,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  busy,
  input  logic                  clear_start,
  output logic                  addr_error
);

  localparam int                  IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t                  state, state_next;
  logic [IDX_W-1:0]        ptr, ptr_next;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    req_ok;
  logic                    wr_in_range, rd_in_range;
  logic                    wr_accept, rd_accept, wr_commit;
  logic [IDX_W-1:0]        wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0]   rd_word;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      ST_CLEAR: begin
        ptr_next = ptr + IDX_W'(1);
        if (ptr == LAST_IDX) begin
          state_next = ST_IDLE;
          ptr_next   = '0;
        end
      end
      ST_IDLE: begin
        if (clear_start) begin
          state_next = ST_CLEAR;
          ptr_next   = '0;
        end
      end
      default: begin
        state_next = ST_CLEAR;
        ptr_next   = '0;
      end
    endcase
  end

  assign busy = (state == ST_CLEAR);

  // The cycle that launches a clear also swallows any request presented with it.
  assign req_ok      = (state == ST_IDLE) && !clear_start;
  assign wr_in_range = {1'b0, write_addr} < DEPTH_W;
  assign rd_in_range = {1'b0, read_addr} < DEPTH_W;
  assign wr_accept   = enable_write && req_ok;
  assign rd_accept   = enable_read && req_ok;
  assign wr_commit   = wr_accept && wr_in_range;
  assign wr_idx      = write_addr[IDX_W-1:0];
  assign rd_idx      = rd_in_range ? read_addr[IDX_W-1:0] : '0;

  always_ff @(posedge clock) begin
    if (state == ST_CLEAR) begin
      mem[ptr] <= CLEAR_VALUE;
    end else if (wr_commit) begin
      mem[wr_idx] <= write_data;
    end
  end

  // Write-first: a same-edge write to the read address wins over the stored word.
  always_comb begin
    rd_word = '0;
    if (wr_commit && (write_addr == read_addr)) begin
      rd_word = write_data;
    end else if (rd_in_range) begin
      rd_word = mem[rd_idx];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_error <= 1'b0;
    end else begin
      addr_error <= (wr_accept && !wr_in_range) || (rd_accept && !rd_in_range);
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s1_valid;
      logic [DATA_WIDTH-1:0] s1_data;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          s1_valid   <= 1'b0;
          s1_data    <= '0;
          read_valid <= 1'b0;
          read_data  <= '0;
        end else begin
          s1_valid   <= rd_accept;
          if (rd_accept) begin
            s1_data <= rd_word;
          end
          read_valid <= s1_valid;
          if (s1_valid) begin
            read_data <= s1_data;
          end
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          read_valid <= 1'b0;
          read_data  <= '0;
        end else begin
          read_valid <= rd_accept;
          if (rd_accept) begin
            read_data <= rd_word;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_param_data_memory.sv
// Bench for param_data_memory: three builds (default, DEPTH=200, READ_LATENCY=2)
// share one stimulus stream; each is checked against hand-computed values.
module tb_param_data_memory;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable_write, enable_read, clear_start;
  logic [7:0] write_addr, read_addr, write_data;

  logic [7:0] rd_a, rd_b, rd_c;
  logic       rv_a, rv_b, rv_c;
  logic       busy_a, busy_b, busy_c;
  logic       err_a, err_b, err_c;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  param_data_memory u_a (
    .clock(clock), .reset_n(reset_n),
    .enable_write(enable_write), .write_addr(write_addr), .write_data(write_data),
    .enable_read(enable_read), .read_addr(read_addr),
    .read_data(rd_a), .read_valid(rv_a), .busy(busy_a),
    .clear_start(clear_start), .addr_error(err_a)
  );

  param_data_memory #(.DEPTH(200)) u_b (
    .clock(clock), .reset_n(reset_n),
    .enable_write(enable_write), .write_addr(write_addr), .write_data(write_data),
    .enable_read(enable_read), .read_addr(read_addr),
    .read_data(rd_b), .read_valid(rv_b), .busy(busy_b),
    .clear_start(clear_start), .addr_error(err_b)
  );

  param_data_memory #(.READ_LATENCY(2)) u_c (
    .clock(clock), .reset_n(reset_n),
    .enable_write(enable_write), .write_addr(write_addr), .write_data(write_data),
    .enable_read(enable_read), .read_addr(read_addr),
    .read_data(rd_c), .read_valid(rv_c), .busy(busy_c),
    .clear_start(clear_start), .addr_error(err_c)
  );

  typedef struct {
    logic       we;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       re;
    logic [7:0] raddr;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [16];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic we, input logic [7:0] waddr,
                                input logic [7:0] wdata, input logic re,
                                input logic [7:0] raddr);
    enable_write = we;
    write_addr   = waddr;
    write_data   = wdata;
    enable_read  = re;
    read_addr    = raddr;
    step();
  endtask

  task automatic idle_inputs();
    enable_write = 1'b0;
    write_addr   = '0;
    write_data   = '0;
    enable_read  = 1'b0;
    read_addr    = '0;
    clear_start  = 1'b0;
  endtask

  // Counts sampled cycles with busy high, starting with the current sample.
  task automatic count_busy(output int na, output int nb, output int nc);
    na = busy_a ? 1 : 0;
    nb = busy_b ? 1 : 0;
    nc = busy_c ? 1 : 0;
    for (int i = 0; i < 1000 && (busy_a || busy_b || busy_c); i++) begin
      step();
      if (busy_a) na++;
      if (busy_b) nb++;
      if (busy_c) nc++;
    end
  endtask

  initial begin
    int na, nb, nc, ea, eb, ec;

    vecs[0]  = '{1'b0, 8'd0, 8'h00, 1'b1, 8'd0,   1'b1, 8'h00};
    vecs[1]  = '{1'b0, 8'd0, 8'h00, 1'b1, 8'd1,   1'b1, 8'h00};
    vecs[2]  = '{1'b0, 8'd0, 8'h00, 1'b1, 8'd255, 1'b1, 8'h00};
    vecs[3]  = '{1'b0, 8'd0, 8'h00, 1'b0, 8'd0,   1'b0, 8'h00};
    vecs[4]  = '{1'b1, 8'd0, 8'h04, 1'b0, 8'd0,   1'b0, 8'h00};
    vecs[5]  = '{1'b1, 8'd1, 8'h05, 1'b0, 8'd0,   1'b0, 8'h00};
    vecs[6]  = '{1'b1, 8'd2, 8'h06, 1'b0, 8'd0,   1'b0, 8'h00};
    vecs[7]  = '{1'b0, 8'd0, 8'h00, 1'b1, 8'd0,   1'b1, 8'h04};
    vecs[8]  = '{1'b0, 8'd0, 8'h00, 1'b1, 8'd1,   1'b1, 8'h05};
    vecs[9]  = '{1'b0, 8'd0, 8'h00, 1'b1, 8'd2,   1'b1, 8'h06};
    vecs[10] = '{1'b0, 8'd0, 8'h00, 1'b0, 8'd0,   1'b0, 8'h06};
    vecs[11] = '{1'b1, 8'd5, 8'hAA, 1'b1, 8'd5,   1'b1, 8'hAA};
    vecs[12] = '{1'b0, 8'd0, 8'h00, 1'b1, 8'd5,   1'b1, 8'hAA};
    vecs[13] = '{1'b1, 8'd3, 8'h11, 1'b1, 8'd2,   1'b1, 8'h06};
    vecs[14] = '{1'b0, 8'd0, 8'h00, 1'b1, 8'd3,   1'b1, 8'h11};
    vecs[15] = '{1'b0, 8'd0, 8'h00, 1'b0, 8'd0,   1'b0, 8'h11};

    idle_inputs();
    reset_n = 1'b0;
    #2;
    check_output("reset rd_a", 32'(rd_a), 32'h00);
    check_output("reset rv_a", 32'(rv_a), 32'd0);
    check_output("reset err_a", 32'(err_a), 32'd0);
    check_output("reset busy_a", 32'(busy_a), 32'd1);
    step();
    step();
    reset_n = 1'b1;
    count_busy(na, nb, nc);
    check_output("init busy cycles a", 32'(na), 32'd256);
    check_output("init busy cycles b", 32'(nb), 32'd200);
    check_output("init busy cycles c", 32'(nc), 32'd256);

    // Basic reads, writes, back-to-back reads and write-first forwarding.
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].re, vecs[i].raddr);
      check_output($sformatf("vec%0d valid", i), 32'(rv_a), 32'(vecs[i].exp_valid));
      check_output($sformatf("vec%0d data", i), 32'(rd_a), 32'(vecs[i].exp_data));
      check_output($sformatf("vec%0d err", i), 32'(err_a), 32'd0);
    end

    // Out-of-range handling on the 200-word build.
    apply_stimulus(1'b1, 8'd250, 8'h77, 1'b0, 8'd0);
    check_output("oor write err_b", 32'(err_b), 32'd1);
    check_output("oor write err_a", 32'(err_a), 32'd0);
    check_output("oor write rv_b", 32'(rv_b), 32'd0);
    apply_stimulus(1'b0, 8'd0, 8'h00, 1'b0, 8'd0);
    check_output("oor write pulse end", 32'(err_b), 32'd0);
    apply_stimulus(1'b0, 8'd0, 8'h00, 1'b1, 8'd250);
    check_output("oor read rv_b", 32'(rv_b), 32'd1);
    check_output("oor read rd_b", 32'(rd_b), 32'h00);
    check_output("oor read err_b", 32'(err_b), 32'd1);
    check_output("full depth rd_a 250", 32'(rd_a), 32'h77);
    check_output("full depth err_a", 32'(err_a), 32'd0);
    apply_stimulus(1'b0, 8'd0, 8'h00, 1'b1, 8'd50);
    check_output("no alias rd_b 50", 32'(rd_b), 32'h00);
    check_output("no alias err_b", 32'(err_b), 32'd0);
    apply_stimulus(1'b1, 8'd220, 8'h12, 1'b1, 8'd230);
    check_output("dual oor err_b", 32'(err_b), 32'd1);
    apply_stimulus(1'b0, 8'd0, 8'h00, 1'b0, 8'd0);
    check_output("dual oor single pulse", 32'(err_b), 32'd0);
    apply_stimulus(1'b1, 8'd200, 8'h99, 1'b1, 8'd199);
    check_output("boundary err_b", 32'(err_b), 32'd1);
    check_output("boundary rd_b 199", 32'(rd_b), 32'h00);
    apply_stimulus(1'b0, 8'd0, 8'h00, 1'b1, 8'd0);
    check_output("in-range kept rd_b 0", 32'(rd_b), 32'h04);
    check_output("in-range err_b", 32'(err_b), 32'd0);

    // Two-edge read latency: three consecutive reads.
    apply_stimulus(1'b0, 8'd0, 8'h00, 1'b0, 8'd0);
    apply_stimulus(1'b0, 8'd0, 8'h00, 1'b0, 8'd0);
    apply_stimulus(1'b0, 8'd0, 8'h00, 1'b1, 8'd0);
    check_output("lat2 +1 rv_c", 32'(rv_c), 32'd0);
    check_output("lat1 ref rd_a", 32'(rd_a), 32'h04);
    apply_stimulus(1'b0, 8'd0, 8'h00, 1'b1, 8'd1);
    check_output("lat2 rv_c 0", 32'(rv_c), 32'd1);
    check_output("lat2 rd_c 0", 32'(rd_c), 32'h04);
    apply_stimulus(1'b0, 8'd0, 8'h00, 1'b1, 8'd2);
    check_output("lat2 rv_c 1", 32'(rv_c), 32'd1);
    check_output("lat2 rd_c 1", 32'(rd_c), 32'h05);
    apply_stimulus(1'b0, 8'd0, 8'h00, 1'b0, 8'd0);
    check_output("lat2 rv_c 2", 32'(rv_c), 32'd1);
    check_output("lat2 rd_c 2", 32'(rd_c), 32'h06);
    apply_stimulus(1'b0, 8'd0, 8'h00, 1'b0, 8'd0);
    check_output("lat2 drain rv_c", 32'(rv_c), 32'd0);
    check_output("lat2 hold rd_c", 32'(rd_c), 32'h06);

    // Clear launch: same-cycle requests ignored, in-flight read still completes.
    apply_stimulus(1'b0, 8'd0, 8'h00, 1'b1, 8'd1);
    check_output("pre-clear rd_a", 32'(rd_a), 32'h05);
    clear_start = 1'b1;
    apply_stimulus(1'b1, 8'd7, 8'h33, 1'b1, 8'd0);
    clear_start = 1'b0;
    check_output("clear busy_a", 32'(busy_a), 32'd1);
    check_output("clear ignored rv_a", 32'(rv_a), 32'd0);
    check_output("clear hold rd_a", 32'(rd_a), 32'h05);
    check_output("in-flight rv_c", 32'(rv_c), 32'd1);
    check_output("in-flight rd_c", 32'(rd_c), 32'h05);
    ea = busy_a ? 1 : 0;
    eb = busy_b ? 1 : 0;
    ec = busy_c ? 1 : 0;
    apply_stimulus(1'b1, 8'd250, 8'h55, 1'b1, 8'd250);
    check_output("busy no err_b", 32'(err_b), 32'd0);
    check_output("busy no rv_b", 32'(rv_b), 32'd0);
    check_output("busy no rv_c", 32'(rv_c), 32'd0);
    idle_inputs();
    count_busy(na, nb, nc);
    check_output("clear busy cycles a", 32'(na + ea), 32'd256);
    check_output("clear busy cycles b", 32'(nb + eb), 32'd200);
    check_output("clear busy cycles c", 32'(nc + ec), 32'd256);
    apply_stimulus(1'b0, 8'd0, 8'h00, 1'b1, 8'd7);
    check_output("post-clear rd_a 7", 32'(rd_a), 32'h00);
    check_output("post-clear rv_a 7", 32'(rv_a), 32'd1);
    apply_stimulus(1'b0, 8'd0, 8'h00, 1'b1, 8'd0);
    check_output("post-clear rd_a 0", 32'(rd_a), 32'h00);
    check_output("post-clear rd_b 0", 32'(rd_b), 32'h00);
    apply_stimulus(1'b0, 8'd0, 8'h00, 1'b1, 8'd5);
    check_output("post-clear rd_a 5", 32'(rd_a), 32'h00);

    // Reset asserted mid-clear restarts the full clear.
    apply_stimulus(1'b1, 8'd9, 8'h5A, 1'b0, 8'd0);
    apply_stimulus(1'b0, 8'd0, 8'h00, 1'b1, 8'd9);
    check_output("pre-reset rd_a", 32'(rd_a), 32'h5A);
    idle_inputs();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (50) step();
    check_output("mid-clear busy_a", 32'(busy_a), 32'd1);
    check_output("mid-clear hold rd_a", 32'(rd_a), 32'h5A);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async reset rd_a", 32'(rd_a), 32'h00);
    check_output("async reset rv_a", 32'(rv_a), 32'd0);
    check_output("async reset busy_a", 32'(busy_a), 32'd1);
    step();
    step();
    reset_n = 1'b1;
    count_busy(na, nb, nc);
    check_output("restart busy cycles a", 32'(na), 32'd256);
    check_output("restart busy cycles b", 32'(nb), 32'd200);
    apply_stimulus(1'b0, 8'd0, 8'h00, 1'b1, 8'd9);
    check_output("post-restart rd_a 9", 32'(rd_a), 32'h00);
    check_output("post-restart rv_a 9", 32'(rv_a), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
